// File: rtl/instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_buffer
//
// Purpose:
//   Instruction memory front end between the fetch stage and a single-port
//   instruction memory. Sequential words are prefetched into a DEPTH-entry
//   FIFO so straight-line code completes a fetch in the same cycle it is
//   requested. A non-sequential request flushes the FIFO and restarts the
//   stream at the new address. Memory read latency may vary (>= 1 cycle);
//   at most one read is outstanding at any time.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   fetch_req      in   core requests the word at addr (held until fetch_valid)
//   addr           in   requested word address
//   fetch_valid    out  data_read carries the word for addr this cycle
//   data_read      out  instruction word (0 when fetch_valid=0)
//   mem_addr       out  memory read address (registered)
//   mem_read_en    out  one-cycle memory read request pulse (registered)
//   mem_read_val   in   memory read data
//   mem_read_valid in   memory response strobe
//   hit_count      out  (IFETCH_STATS_EN only) completed fetches, wraps at 2^32
//   miss_count     out  (IFETCH_STATS_EN only) stream restarts, wraps at 2^32
//
// Configuration:
//   Define IFETCH_STATS_EN to add the hit_count/miss_count statistics ports.
// ---------------------------------------------------------------------------
module instruction_prefetch_buffer #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256,
    parameter int DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_req,
    input  logic [$clog2(MEM_SIZE)-1:0] addr,
    output logic                        fetch_valid,
    output logic [MEM_WIDTH-1:0]        data_read,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic                        mem_read_en,
    input  logic [MEM_WIDTH-1:0]        mem_read_val,
    input  logic                        mem_read_valid
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count
`endif
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_reg;
    logic [AW-1:0]       base_reg;       // address of the FIFO head word
    logic [AW-1:0]       next_addr_reg;  // next word to request from memory
    logic [PW:0]         count_reg;
    logic [PW-1:0]       head_reg;
    logic [PW-1:0]       tail_reg;
    logic                pending_reg;    // one read outstanding
    logic                drop_reg;       // outstanding read belongs to a flushed stream
    logic                mem_read_en_reg;
    logic [AW-1:0]       mem_addr_reg;
    logic [MEM_WIDTH-1:0] fifo_mem [DEPTH];

    logic hit;
    logic wait_base;
    logic miss;
    logic resp;
    logic push;
    logic issue;

    // Address increment modulo MEM_SIZE (MEM_SIZE need not be a power of two).
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == AW'(MEM_SIZE - 1)) ? '0 : a + AW'(1);
    endfunction

    always_comb begin
        hit = fetch_req && (state_reg == STREAM) && (count_reg != '0) && (addr == base_reg);

        // With an empty FIFO the stream always points at base: either the
        // read for base is in flight, a stale read is draining before base
        // is requested, or base is about to be issued. A request for base in
        // that situation is a wait, never a restart.
        wait_base = (state_reg == STREAM) && (count_reg == '0) && (addr == base_reg);

        // In IDLE nothing is tracked, so the first request is always a restart.
        miss = fetch_req && !hit && !wait_base;

        resp  = mem_read_valid && pending_reg;
        // A flush in the same cycle as a response discards the response.
        push  = resp && !drop_reg && !miss;
        // !pending plus count<DEPTH keeps count+pending <= DEPTH.
        issue = (state_reg == STREAM) && !pending_reg && (count_reg < (PW+1)'(DEPTH)) && !miss;
    end

    // Head is read combinationally so a hit completes in the request cycle.
    assign fetch_valid = hit;
    assign data_read   = hit ? fifo_mem[head_reg] : '0;
    assign mem_read_en = mem_read_en_reg;
    assign mem_addr    = mem_addr_reg;

    // FIFO storage: one write-enabled register per entry, no reset needed
    // because count gates every read.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PW'(gi))) begin
                    fifo_mem[gi] <= mem_read_val;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            next_addr_reg   <= '0;
            count_reg       <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            pending_reg     <= 1'b0;
            drop_reg        <= 1'b0;
            mem_read_en_reg <= 1'b0;
            mem_addr_reg    <= '0;
        end else begin
            mem_read_en_reg <= issue;
            if (issue) begin
                mem_addr_reg <= next_addr_reg;
            end

            if (miss) begin
                state_reg     <= STREAM;
                count_reg     <= '0;
                head_reg      <= '0;
                tail_reg      <= '0;
                base_reg      <= addr;
                next_addr_reg <= addr;
                // A read still outstanding after this edge must be discarded;
                // one returning in this very cycle is already gone.
                pending_reg   <= pending_reg && !mem_read_valid;
                drop_reg      <= pending_reg && !mem_read_valid;
            end else begin
                // issue requires !pending and resp requires pending: exclusive.
                if (issue) begin
                    next_addr_reg <= wrap_inc(next_addr_reg);
                    pending_reg   <= 1'b1;
                end else if (resp) begin
                    pending_reg <= 1'b0;
                    drop_reg    <= 1'b0;
                end

                if (push) begin
                    tail_reg <= tail_reg + PW'(1);
                end
                if (hit) begin
                    head_reg <= head_reg + PW'(1);
                    base_reg <= wrap_inc(base_reg);
                end
                count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, hit};
            end
        end
    end

`ifdef IFETCH_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instruction_prefetch_buffer
//
// Self-checking bench for instruction_prefetch_buffer. A behavioural memory
// with selectable latency answers read pulses; fetch sequences come from a
// table of {address, expected cycles-to-complete}, expected data from the
// memory content function. Hand-written sequences cover the stray response
// in IDLE, FIFO fill during a core stall and reset during an in-flight read.
// ---------------------------------------------------------------------------
module tb_instruction_prefetch_buffer;

    localparam int MW = 32;
    localparam int MS = 256;
    localparam int D  = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [AW-1:0] addr;
    logic          fetch_valid;
    logic [MW-1:0] data_read;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic [MW-1:0] mem_read_val;
    logic          mem_read_valid;
`ifdef IFETCH_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    instruction_prefetch_buffer #(
        .MEM_WIDTH(MW),
        .MEM_SIZE (MS),
        .DEPTH    (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .addr          (addr),
        .fetch_valid   (fetch_valid),
        .data_read     (data_read),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_read_val  (mem_read_val),
        .mem_read_valid(mem_read_valid)
`ifdef IFETCH_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- memory model ----------------
    function automatic logic [MW-1:0] mem_word(input logic [AW-1:0] a);
        return {16'hC0DE, ~a, a};
    endfunction

    int            lat = 1;          // read latency in cycles, 1..4
    bit [3:0]      lat_v;
    logic [AW-1:0] lat_a [4];
    logic          stray_valid;

    always @(posedge clk) begin
        lat_v    <= {lat_v[2:0], mem_read_en};
        lat_a[0] <= mem_addr;
        lat_a[1] <= lat_a[0];
        lat_a[2] <= lat_a[1];
        lat_a[3] <= lat_a[2];
    end

    assign mem_read_valid = lat_v[lat-1] | stray_valid;
    assign mem_read_val   = mem_word(lat_a[lat-1]);

    // Read-request monitor.
    int            en_pulses = 0;
    logic [AW-1:0] last_en_addr = '0;
    always @(negedge clk) begin
        if (mem_read_en) begin
            en_pulses    <= en_pulses + 1;
            last_en_addr <= mem_addr;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, " data_read"},   data_read,        32'd0);
        chk({tag, " mem_read_en"}, 32'(mem_read_en), 32'd0);
        chk({tag, " mem_addr"},    32'(mem_addr),    32'd0);
    endtask

    // Called just after a rising edge; exp_cyc=0 leaves latency unchecked.
    task automatic do_fetch(input logic [AW-1:0] a, input int exp_cyc, input string tag);
        int            cyc;
        bit            got;
        logic [MW-1:0] d;
        cyc = 0;
        got = 1'b0;
        d   = '0;
        fetch_req = 1'b1;
        addr      = a;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (fetch_valid) begin
                got = 1'b1;
                d   = data_read;
            end
        end
        chk({tag, " completed"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, " data"}, d, mem_word(a));
            if (exp_cyc != 0) chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        end
        $display("fetch %s addr=%02h data=%08h cycles=%0d", tag, a, d, cyc);
        @(posedge clk);
        #1 fetch_req = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] a;
        int            cyc;
    } vec_t;

    vec_t vt [15];

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int            e0;
        int            bad;
        int            k;
        bit            found;
        bit            saw_valid;

        // Latency 1: miss = 5 cycles, sequential refill = 3 cycles,
        // restart with a read in flight (dropped) = 6 cycles.
        vt[0]  = '{8'h00, 5};
        vt[1]  = '{8'h01, 3};
        vt[2]  = '{8'h02, 3};
        vt[3]  = '{8'h03, 3};
        vt[4]  = '{8'h04, 3};
        vt[5]  = '{8'h05, 3};
        vt[6]  = '{8'h06, 3};
        vt[7]  = '{8'h07, 3};
        vt[8]  = '{8'hFE, 6};   // wrap sequence
        vt[9]  = '{8'hFF, 3};
        vt[10] = '{8'h00, 3};   // sequential across 0xFF -> 0x00, not a miss
        vt[11] = '{8'h10, 5};   // after reset
        vt[12] = '{8'h11, 3};
        vt[13] = '{8'h12, 3};
        vt[14] = '{8'h40, 6};   // jump while 0x13 is in flight

        reset       = 1'b1;
        fetch_req   = 1'b0;
        addr        = '0;
        stray_valid = 1'b0;
        do_reset();

        // Reset state, then a stray response while IDLE.
        @(negedge clk);
        check_idle_outputs("reset");
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        check_idle_outputs("stray");
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            if (i == 11) do_reset();
            do_fetch(vt[i].a, vt[i].cyc, $sformatf("vec%0d", i));
        end
        chk("jump last mem_addr", 32'(last_en_addr), 32'h40);
`ifdef IFETCH_STATS_EN
        chk("miss_count", miss_count, 32'd2);
        chk("hit_count",  hit_count,  32'd4);
`endif

        // Stall with latency 3: FIFO fills to DEPTH, then requests stop.
        do_reset();
        lat = 3;
        repeat (6) @(posedge clk);
        #1;
        do_fetch(8'h80, 7, "stall0");
        e0 = en_pulses;
        repeat (30) @(posedge clk);
        #1;
        chk("fill pulses",    32'(en_pulses - e0), 32'(D));
        chk("fill last addr", 32'(last_en_addr),   32'h84);
        @(negedge clk);
        chk("fill stopped",   32'(mem_read_en),    32'd0);
        @(posedge clk);
        #1;
        for (int i = 1; i <= D; i++) begin
            do_fetch(8'(8'h80 + i), 1, $sformatf("warm%0d", i));
        end

        // Reset while a read is in flight; the late response is ignored.
        do_fetch(8'h90, 0, "restart");
        found = 1'b0;
        k = 0;
        while (!found && k < 20) begin
            @(negedge clk);
            k++;
            if (mem_read_en) found = 1'b1;
        end
        chk("inflight read seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        bad = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fetch_valid || mem_read_en) bad++;
            if (mem_read_valid) saw_valid = 1'b1;
        end
        chk("late resp arrived", 32'(saw_valid), 32'd1);
        chk("late resp ignored", 32'(bad),       32'd0);
        @(posedge clk);
        #1;
        do_fetch(8'h20, 7, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
